// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - registered 1-to-N valid/ready demux, one holding register per lane; DEMUX_DROP_CNT_EN adds drop_count
module stream_demux #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SEL_W-1:0]     in_sel,
  output logic                 in_ready,
  output logic [N-1:0]         out_valid,
  output logic [N*WIDTH-1:0]   out_data,
`ifdef DEMUX_DROP_CNT_EN
  output logic [7:0]           drop_count,
`endif
  input  logic [N-1:0]         out_ready
);

  localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N);

  logic [N-1:0]            valid_q, valid_d;
  logic [N-1:0][WIDTH-1:0] data_q, data_d;
  logic                    sel_bad;
  logic                    lane_busy;
  logic                    accept;

  assign sel_bad = ({1'b0, in_sel} >= N_EXT);

  // Only a full lane that is not draining this cycle can refuse a transfer.
  always_comb begin
    lane_busy = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (in_sel == SEL_W'(k) && valid_q[k] && !out_ready[k]) lane_busy = 1'b1;
    end
  end

  assign in_ready = enable && !lane_busy;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int k = 0; k < N; k++) begin
      if (accept && !sel_bad && in_sel == SEL_W'(k)) begin
        valid_d[k] = 1'b1;
        data_d[k]  = in_data;
      end else if (valid_q[k] && out_ready[k]) begin
        valid_d[k] = 1'b0;
        data_d[k]  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

`ifdef DEMUX_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (accept && sel_bad && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - randomized and directed bench for stream_demux against a per-lane queue model
module tb_stream_demux;
  parameter int WIDTH = 8;
  parameter int N     = 4;
  localparam int SEL_W = $clog2(N);

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic                 in_valid;
  logic [WIDTH-1:0]     in_data;
  logic [SEL_W-1:0]     in_sel;
  logic                 in_ready;
  logic [N-1:0]         out_valid;
  logic [N*WIDTH-1:0]   out_data;
  logic [N-1:0]         out_ready;
`ifdef DEMUX_DROP_CNT_EN
  logic [7:0]           drop_count;
`endif

  stream_demux #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_sel(in_sel),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
`ifdef DEMUX_DROP_CNT_EN
    .drop_count(drop_count),
`endif
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference: each lane is a queue holding at most one transfer.
  logic [WIDTH-1:0] lane_q[N][$];
  int               exp_drops = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] exp_valid();
    logic [N-1:0] v = '0;
    for (int k = 0; k < N; k++) v[k] = (lane_q[k].size() != 0);
    return v;
  endfunction

  function automatic logic [N*WIDTH-1:0] exp_data();
    logic [N*WIDTH-1:0] d = '0;
    for (int k = 0; k < N; k++)
      if (lane_q[k].size() != 0) d[k*WIDTH +: WIDTH] = lane_q[k][0];
    return d;
  endfunction

  task automatic check_outputs(input string tag);
    check_eq({tag, ".valid"}, 64'(out_valid), 64'(exp_valid()));
    check_eq({tag, ".data"}, 64'(out_data), 64'(exp_data()));
`ifdef DEMUX_DROP_CNT_EN
    check_eq({tag, ".drops"}, 64'(drop_count), 64'(exp_drops));
`endif
  endtask

  task automatic clear_model();
    for (int k = 0; k < N; k++) lane_q[k].delete();
    exp_drops = 0;
  endtask

  task automatic cycle(input string tag, input bit en, input bit v, input logic [WIDTH-1:0] d,
                       input int sel, input logic [N-1:0] ordy);
    bit bad;
    bit exp_rdy;
    @(negedge clk);
    enable = en; in_valid = v; in_data = d; in_sel = SEL_W'(sel); out_ready = ordy;
    #1;
    bad = (sel >= N);
    if (!en)                          exp_rdy = 1'b0;
    else if (bad)                     exp_rdy = 1'b1;
    else if (lane_q[sel].size() == 0) exp_rdy = 1'b1;
    else                              exp_rdy = ordy[sel];
    check_eq({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    for (int k = 0; k < N; k++)
      if (lane_q[k].size() != 0 && ordy[k]) void'(lane_q[k].pop_front());
    if (v && exp_rdy) begin
      if (bad) begin
        if (exp_drops < 255) exp_drops++;
      end else begin
        lane_q[sel].push_back(d);
      end
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    logic [N-1:0] all_rdy;
    logic [N-1:0] ordy;
    all_rdy = '1;
    reset = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-traffic
    cycle("load_a5", 1, 1, 8'hA5, 2, '0);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    clear_model();
    check_eq("midrst.valid", 64'(out_valid), 64'd0);
    check_eq("midrst.data", 64'(out_data), 64'd0);
    @(negedge clk);
    reset = 1'b0; enable = 1'b1; in_sel = '0; out_ready = '0;
    #1;
    check_eq("post_rst.in_ready", 64'(in_ready), 64'd1);

    // Basic route, one lane valid at a time
    cycle("route0", 1, 1, 8'h11, 0, all_rdy);
    check_eq("route0.lane0", 64'(out_data[0 +: WIDTH]), 64'h11);
    cycle("route1", 1, 1, 8'h22, 1, all_rdy);
    check_eq("route1.lane1", 64'(out_data[WIDTH +: WIDTH]), 64'h22);
    cycle("route2", 1, 1, 8'h33, 2, all_rdy);
    cycle("route3", 1, 1, 8'h44, 3, all_rdy);
    cycle("route_idle", 1, 0, 8'h00, 0, all_rdy);

    // Stall isolation on lane 1
    ordy = all_rdy; ordy[1] = 1'b0;
    cycle("stall_5a", 1, 1, 8'h5A, 1, ordy);
    check_eq("stall.hold", 64'(out_data[WIDTH +: WIDTH]), 64'h5A);
    cycle("stall_6b_blocked", 1, 1, 8'h6B, 1, ordy);
    check_eq("stall.blocked", 64'(in_ready), 64'd0);
    cycle("stall_6b_load", 1, 1, 8'h6B, 1, all_rdy);
    check_eq("stall.6b", 64'(out_data[WIDTH +: WIDTH]), 64'h6B);
    cycle("stall_7c", 1, 1, 8'h7C, 3, all_rdy);
    cycle("stall_idle", 1, 0, 8'h00, 0, all_rdy);

    // Drain and load lane 0 in the same cycle
    cycle("dl_01", 1, 1, 8'h01, 0, '0);
    cycle("dl_02", 1, 1, 8'h02, 0, all_rdy);
    check_eq("dl.valid0", 64'(out_valid[0]), 64'd1);
    check_eq("dl.data0", 64'(out_data[0 +: WIDTH]), 64'h02);
    cycle("dl_idle", 1, 0, 8'h00, 0, all_rdy);

    // Enable gating: lane 2 drains, nothing loads
    cycle("en_c3", 1, 1, 8'hC3, 2, '0);
    ordy = '0; ordy[2] = 1'b1;
    cycle("en_off", 0, 1, 8'h99, 2, ordy);
    check_eq("en_off.valid2", 64'(out_valid[2]), 64'd0);
    check_eq("en_off.data2", 64'(out_data[2*WIDTH +: WIDTH]), 64'd0);

`ifdef DEMUX_DROP_CNT_EN
    // Highest select code; out of range whenever N is not a power of two
    for (int i = 0; i < 3; i++) cycle("badsel", 1, 1, 8'hEE, (1 << SEL_W) - 1, all_rdy);
    for (int i = 0; i < 300; i++) cycle("sat", 1, 1, 8'hEE, (1 << SEL_W) - 1, all_rdy);
    check_eq("drop_sat", 64'(drop_count), 64'(exp_drops));
`endif

    // Randomized traffic over the full select code space
    for (int i = 0; i < 600; i++) begin
      cycle("rand", ($urandom_range(0, 7) != 0), $urandom_range(0, 1), WIDTH'($urandom),
            int'($urandom_range(0, (1 << SEL_W) - 1)), N'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Parametrised, registered successor to the team's 1-to-4 combinational demux.
- Routes a valid/ready data stream to one of N output channels, chosen per transfer by a select field.
- Each output lane has a one-entry holding register, so a stalled lane never blocks traffic to the other lanes.
- Sits between a single producer and N independent consumers in the lab datapath.

Parameters:
- WIDTH, 8, data bits per transfer (>=1).
- N, 4, number of output channels (>=2).
- SEL_W, $clog2(N), select width. Derived; never overridden.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  global accept enable. Low: no new transfers accepted; held lanes still drain.
- in_valid  input  1  producer has a transfer.
- in_data  input  WIDTH  transfer payload.
- in_sel  input  SEL_W  destination channel index.
- in_ready  output  1  block accepts the transfer this cycle.
- out_valid  output  N  bit k: lane k holds data.
- out_data  output  N*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- out_ready  input  N  bit k: consumer k takes lane k this cycle.

Behaviour:
- Reset (async assert, sync release): out_valid = 0, all out_data lanes = 0. Any held data is discarded, including reset asserted mid-stream.
- Transfer accepted on a rising clk when in_valid && in_ready.
- Lane k drains on a rising clk when out_valid[k] && out_ready[k].
- in_ready is combinational: enable && (sel_bad || !out_valid[in_sel] || out_ready[in_sel]).
  - sel_bad = (in_sel >= N). It can only be true when N is not a power of 2.
  - in_ready does not depend on in_valid.
- Accept with a good select:
  - Lane in_sel loads in_data.
  - out_valid[in_sel] = 1 on the next cycle. Latency is 1 cycle.
- Accept with sel_bad:
  - The transfer is consumed and dropped.
  - No lane changes.
- Same-lane drain and load in one cycle:
  - The new data replaces the old.
  - out_valid stays 1, giving full throughput of 1 transfer per cycle per lane.
- Drain with no reload:
  - out_valid[k] -> 0.
  - Lane data cleared to 0. A non-valid lane always reads 0.
- Different lanes:
  - Fully independent. Lane j may drain in the same cycle lane k loads.
  - A full, stalled lane k only blocks transfers addressed to k.
- Held lane k:
  - out_data lane is stable while out_valid[k] && !out_ready[k].
  - out_valid[k] cannot drop without a drain.
- enable low:
  - in_ready = 0 and nothing is accepted.
  - Drains continue normally.
  - enable toggling never corrupts held data.
- out_ready[k] while out_valid[k] = 0 is ignored.
- No internal state machine beyond the per-lane valid/data registers. Each lane is a 2-state (EMPTY/FULL) machine:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on drain+load or stall.

Optional Feature:
- Macro DEMUX_DROP_CNT_EN.
- Defined:
  - Adds output port drop_count, 8 bits.
  - Saturating counter incremented on each accepted sel_bad transfer; holds at 255.
  - Reset to 0.
- Undefined:
  - Port and counter absent.
  - sel_bad transfers are dropped silently; all other behaviour is identical.

Test Plan:
- Reset mid-traffic: load lane 2 with 0xA5, assert reset for 1 cycle -> out_valid = 4'b0000, out_data = 0. After release, in_ready = 1 with enable = 1.
- Basic route: enable = 1, out_ready = 4'b1111; send 0x11/sel 0, 0x22/sel 1, 0x33/sel 2, 0x44/sel 3 on back-to-back cycles -> each appears 1 cycle later on its own lane, one lane valid at a time, in_ready constantly 1.
- Stall isolation: out_ready[1] = 0; send 0x5A/sel 1, then 0x6B/sel 1, then 0x7C/sel 3:
  - Lane 1 holds 0x5A.
  - in_ready = 0 while 0x6B is presented.
  - After out_ready[1] rises, 0x6B loads; then 0x7C reaches lane 3 one cycle after acceptance.
- Drain+load same cycle: lane 0 full with 0x01 and out_ready[0] = 1, present 0x02/sel 0 -> next cycle lane 0 = 0x02, out_valid[0] stays 1, no bubble.
- Enable gating: enable = 0, lane 2 holds 0xC3, out_ready[2] = 1, in_valid = 1 -> in_ready = 0, lane 2 drains to valid 0 / data 0, and no new load occurs.
- Bad select (N = 3, SEL_W = 2, DEMUX_DROP_CNT_EN defined): send 0xEE/sel 3 three times -> in_ready = 1, no lane changes, drop_count = 3. Force 300 drops -> drop_count saturates at 255.
